mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single RAM port (MOV/RW/MOC handshake) on behalf of two requesters: the instruction-fetch path (IR load) and the data path (load/store via MAR/MDR).
- Round-robin arbitration between the two requesters.
- Drives the MOV/RW strobes and waits for MOC.
- Returns read data and a one-cycle ack to the requester.
- A watchdog aborts accesses whose MOC never arrives.

Parameters:
- ADDR_W, 32, width of byte address
- DATA_W, 32, width of data bus
- TIMEOUT, 16, maximum cycles MOV is held waiting for MOC (min 2)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_ack  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request, held until d_ack
- d_rw  in  1  1=read (load), 0=write (store)
- d_size  in  2  00 byte, 01 halfword, 10 word
- d_addr  in  ADDR_W  data address (MAR)
- d_wdata  in  DATA_W  store data (MDR)
- d_ack  out  1  one-cycle completion pulse to data path
- rdata  out  DATA_W  read data, valid in ack cycle, held until next completion
- MOV  out  1  memory operation valid
- RW  out  1  memory direction, 1=read
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_size  out  2  RAM access size
- MOC  in  1  memory operation complete
- mem_rdata  in  DATA_W  RAM read data
- err  out  1  timeout flag, valid in ack cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clr=0, async): state=IDLE. MOV=0, RW=1, mem_addr=0, mem_wdata=0, mem_size=0, if_ack=0, d_ack=0, rdata=0, err=0, busy=0, last_grant=DATA (fetch wins first tie), watchdog=0. Reset mid-access drops MOV immediately; no ack is issued.
- States: IDLE, ACCESS, DONE.
- IDLE, single request:
  - Only if_req: grant FETCH.
  - Only d_req: grant DATA.
- IDLE, both requests: grant the source not equal to last_grant.
- On grant: register mem_addr/mem_wdata/mem_size/RW from the winner, update last_grant, go to ACCESS.
- Fetch grants always use RW=1, mem_size=10, mem_wdata=0.
- No request: stay in IDLE.
- ACCESS:
  - MOV=1; address, data, size and RW are stable for the whole state.
  - Watchdog increments each cycle.
  - MOC=1: capture mem_rdata into rdata (read) or leave rdata unchanged (write), err=0, go to DONE.
  - Else if watchdog==TIMEOUT-1: rdata=0, err=1, go to DONE.
  - MOC and timeout in the same cycle: MOC wins, err=0.
- DONE: MOV=0, watchdog cleared. Pulse if_ack or d_ack (granted source only) for exactly 1 cycle, then return to IDLE.
- Ack timing:
  - Requester drops req on the edge ending the ack cycle, so IDLE never re-grants a completed request.
  - Best-case latency: req seen in IDLE at cycle 0, MOV at cycle 1, MOC at cycle 1, ack at cycle 2.
  - Latency req→ack = 2 + (MOC wait cycles).
- err: held until the next completion; cleared on the next successful ack.
- MOC while IDLE or DONE: ignored.
- req deasserted during ACCESS: the access still completes and ack is still pulsed (protocol violation, no abort).
- Address/data changes from a requester after grant: ignored (registered at grant).
- Both acks are never high in the same cycle. MOV is never high outside ACCESS.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
  - Source ids: SRC_FETCH=1'b0, SRC_DATA=1'b1.
  - Size constants: SZ_BYTE, SZ_HALF, SZ_WORD.
  - RW constants: RW_READ=1, RW_WRITE=0.
- Sub-module moc_watchdog:
  - Inputs: clk, clr, en, clear.
  - Output: expired.
  - Parameterised by TIMEOUT; counter width $clog2(TIMEOUT).

Test Plan:
- Fetch read: if_req=1, if_addr=0x40, RAM returns 0x8210_0005 with MOC 2 cycles after MOV → MOV high 3 cycles with mem_addr=0x40, RW=1, mem_size=10; if_ack pulse at cycle 4; rdata=0x8210_0005; err=0.
- Store: d_req=1, d_rw=0, d_addr=0x100, d_wdata=0xDEADBEEF, d_size=01 → MOV=1, RW=0, mem_wdata=0xDEADBEEF, mem_size=01; d_ack after MOC; rdata unchanged.
- Contention: if_req and d_req both asserted from reset, requesters re-request after each ack → grant order FETCH, DATA, FETCH, DATA; never two acks in one cycle.
- Timeout: d_req read, MOC held 0 → MOV high exactly 16 cycles; d_ack with err=1, rdata=0. Next good access clears err.
- MOC on the last watchdog cycle (cycle 16) → err=0, rdata=mem_rdata.
- Reset mid-ACCESS: clr low asynchronously → MOV=0 and busy=0 within the same cycle; no ack. After release, a pending if_req is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, requester ids,
// access sizes and bus direction.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } arb_state_t;

   typedef enum logic {
      SRC_FETCH = 1'b0,
      SRC_DATA  = 1'b1
   } src_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_moc_watchdog.sv
// Counts cycles spent waiting for MOC; expired fires on the last permitted
// cycle so the arbiter can abort in that same cycle.
module moc_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic clear,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sequencing the single RAM port (MOV/RW/MOC) for the
// instruction-fetch and load/store requesters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              MOV,
   output logic              RW,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        mem_size,
   input  logic              MOC,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err,
   output logic              busy
);

   arb_state_t state, state_nxt;
   src_t       last_grant, winner;
   logic       expired;
   logic       grant_now;

   moc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .clr     (clr),
      .en      (state == ACCESS),
      .clear   (state == DONE),
      .expired (expired)
   );

   always_comb begin
      state_nxt = state;
      winner    = SRC_FETCH;
      grant_now = 1'b0;
      case (state)
         IDLE: begin
            if (if_req && d_req) begin
               winner = (last_grant == SRC_DATA) ? SRC_FETCH : SRC_DATA;
            end else if (d_req) begin
               winner = SRC_DATA;
            end
            if (if_req || d_req) begin
               grant_now = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (MOC || expired) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // last_grant doubles as the owner of the in-flight access, so the ack
   // in DONE is steered by it.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state      <= IDLE;
         last_grant <= SRC_DATA;
         RW         <= RW_READ;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_size   <= SZ_BYTE;
         rdata      <= '0;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_now) begin
            last_grant <= winner;
            if (winner == SRC_FETCH) begin
               mem_addr  <= if_addr;
               mem_wdata <= '0;
               mem_size  <= SZ_WORD;
               RW        <= RW_READ;
            end else begin
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
               mem_size  <= d_size;
               RW        <= d_rw;
            end
         end
         // MOC takes priority over a watchdog expiry in the same cycle.
         if (state == ACCESS) begin
            if (MOC) begin
               err <= 1'b0;
               if (RW == RW_READ) begin
                  rdata <= mem_rdata;
               end
            end else if (expired) begin
               err   <= 1'b1;
               rdata <= '0;
            end
         end
      end
   end

   assign MOV    = (state == ACCESS);
   assign busy   = (state != IDLE);
   assign if_ack = (state == DONE) && (last_grant == SRC_FETCH);
   assign d_ack  = (state == DONE) && (last_grant == SRC_DATA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM responder with per-access MOC delay and a
// scoreboard of expected completions in grant order.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int   ADDR_W  = 32;
   localparam int   DATA_W  = 32;
   localparam int   TIMEOUT = 16;
   localparam logic SF      = 1'b0;
   localparam logic SD      = 1'b1;
   localparam int   NEVER   = 255;

   logic              clk;
   logic              clr;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic              d_req;
   logic              d_rw;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] rdata;
   logic              MOV;
   logic              RW;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [1:0]        mem_size;
   logic              MOC;
   logic [DATA_W-1:0] mem_rdata;
   logic              err;
   logic              busy;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .clr(clr),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack),
      .rdata(rdata), .MOV(MOV), .RW(RW), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_size(mem_size), .MOC(MOC),
      .mem_rdata(mem_rdata), .err(err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One access: request fields, RAM behaviour and the expected completion.
   typedef struct {
      logic        src;
      logic [31:0] addr;
      logic        rw;
      logic [1:0]  size;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rval;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_len;
      int          exp_lat;
   } vec_t;

   typedef struct {
      vec_t v;
      int   t_issue;
   } acc_t;

   acc_t sb[$];
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   mov_cnt  = 0;
   int   last_len = 0;
   int   rereq_f  = 0;
   int   rereq_d  = 0;
   logic moc_idle = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input vec_t v);
      acc_t a;
      a.v       = v;
      a.t_issue = cyc;
      sb.push_back(a);
   endtask

   task automatic drive(input vec_t v);
      if (v.src == SF) begin
         if_addr = v.addr;
         if_req  = 1'b1;
      end else begin
         d_addr  = v.addr;
         d_rw    = v.rw;
         d_size  = v.size;
         d_wdata = v.wdata;
         d_req   = 1'b1;
      end
   endtask

   // Advance one clock; sample outputs 1ns after the edge, then play the RAM.
   task automatic step();
      acc_t a;
      @(posedge clk);
      #1;
      cyc++;
      chk("one_ack", 128'(if_ack && d_ack), 128'(0));
      if (!MOV && mov_cnt != 0) begin
         last_len = mov_cnt;
         mov_cnt  = 0;
      end
      if (if_ack || d_ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", 128'({if_ack, d_ack}), 128'(0));
         end else begin
            a = sb.pop_front();
            chk("ack_src", 128'({if_ack, d_ack}), 128'((a.v.src == SF) ? 2'b10 : 2'b01));
            chk("rdata", 128'(rdata), 128'(a.v.exp_rdata));
            chk("err", 128'(err), 128'(a.v.exp_err));
            chk("mov_len", 128'(last_len), 128'(a.v.exp_len));
            if (a.v.exp_lat != 0) begin
               chk("latency", 128'(cyc - a.t_issue), 128'(a.v.exp_lat));
            end
         end
         if (if_ack) begin
            if (rereq_f > 0) rereq_f--;
            else if_req = 1'b0;
         end
         if (d_ack) begin
            if (rereq_d > 0) rereq_d--;
            else d_req = 1'b0;
         end
      end
      if (MOV) begin
         if (sb.size() == 0) begin
            chk("unexpected_mov", 128'(MOV), 128'(0));
            MOC = 1'b0;
         end else begin
            chk("mem_bus", 128'({mem_addr, RW, mem_size, mem_wdata, busy}),
                128'({sb[0].v.addr, sb[0].v.rw, sb[0].v.size, sb[0].v.wdata, 1'b1}));
            MOC       = (mov_cnt == sb[0].v.delay);
            mem_rdata = sb[0].v.rval;
         end
         mov_cnt++;
      end else begin
         MOC       = moc_idle;
         mem_rdata = 32'h5A5A_5A5A;
      end
   endtask

   // Run until every pushed access has completed, then settle into IDLE.
   task automatic drain(input int budget);
      int b;
      b = budget;
      while (sb.size() > 0 && b > 0) begin
         step();
         b--;
      end
      if (sb.size() > 0) begin
         chk("drain_timeout", 128'(sb.size()), 128'(0));
         sb.delete();
      end
      step();
   endtask

   vec_t tbl[9];
   vec_t v;

   initial begin
      clr = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_rw = 1'b1; d_size = 2'b00; d_addr = '0; d_wdata = '0;
      MOC = 1'b0; mem_rdata = '0;

      //            src addr          rw    size   wdata          dly    rval           exp_rdata      err   len lat
      tbl[0] = '{SF, 32'h0000_0040, 1'b1, 2'b10, 32'h0,         2,     32'h8210_0005, 32'h8210_0005, 1'b0, 3,  4};
      tbl[1] = '{SD, 32'h0000_0100, 1'b0, 2'b01, 32'hDEAD_BEEF, 0,     32'h1111_2222, 32'h8210_0005, 1'b0, 1,  2};
      tbl[2] = '{SD, 32'h0000_0203, 1'b1, 2'b00, 32'h0000_1234, 1,     32'h0000_00A5, 32'h0000_00A5, 1'b0, 2,  3};
      tbl[3] = '{SD, 32'h0000_0300, 1'b1, 2'b10, 32'h0,         NEVER, 32'h1111_1111, 32'h0,         1'b1, 16, 17};
      tbl[4] = '{SF, 32'h0000_0044, 1'b1, 2'b10, 32'h0,         3,     32'h1234_5678, 32'h1234_5678, 1'b0, 4,  5};
      tbl[5] = '{SD, 32'h0000_0400, 1'b1, 2'b10, 32'h0,         15,    32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 16, 17};
      tbl[6] = '{SD, 32'h0000_0500, 1'b0, 2'b10, 32'h0BAD_F00D, NEVER, 32'h2222_2222, 32'h0,         1'b1, 16, 17};
      tbl[7] = '{SF, 32'h0000_0048, 1'b1, 2'b10, 32'h0,         0,     32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1,  2};
      tbl[8] = '{SD, 32'h0000_0601, 1'b0, 2'b00, 32'h0000_00FF, 4,     32'h3333_3333, 32'h0F0F_0F0F, 1'b0, 5,  6};

      // Reset values, with both requesters already waiting.
      v = '{SF, 32'h80, 1'b1, 2'b10, 32'h0, 1, 32'h8080_8080, 32'h8080_8080, 1'b0, 2, 0};
      drive(v); push(v);
      v = '{SD, 32'h900, 1'b1, 2'b10, 32'h0000_0900, 1, 32'h9090_9090, 32'h9090_9090, 1'b0, 2, 0};
      drive(v); push(v);
      v = '{SF, 32'h80, 1'b1, 2'b10, 32'h0, 1, 32'h8181_8181, 32'h8181_8181, 1'b0, 2, 0};
      push(v);
      v = '{SD, 32'h900, 1'b1, 2'b10, 32'h0000_0900, 1, 32'h9191_9191, 32'h9191_9191, 1'b0, 2, 0};
      push(v);
      rereq_f = 1;
      rereq_d = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mov_busy", 128'({MOV, busy}), 128'(0));
      chk("rst_rw", 128'(RW), 128'(1));
      chk("rst_bus", 128'({mem_addr, mem_wdata, mem_size}), 128'(0));
      chk("rst_acks", 128'({if_ack, d_ack}), 128'(0));
      chk("rst_rdata_err", 128'({rdata, err}), 128'(0));

      // Contention from reset: grants must alternate FETCH, DATA, FETCH, DATA.
      clr = 1'b1;
      drain(80);

      // Table of single accesses; the last one runs with MOC stuck high while idle.
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            moc_idle = 1'b1;
            for (int k = 0; k < 3; k++) begin
               step();
               chk("moc_idle_ignored", 128'({MOV, busy}), 128'(0));
            end
         end
         drive(tbl[i]);
         push(tbl[i]);
         drain(60);
      end
      moc_idle = 1'b0;
      step();

      // Requester drops req and scrambles its inputs after the grant.
      v = '{SD, 32'h700, 1'b1, 2'b10, 32'h0000_0777, 3, 32'h7777_7777, 32'h7777_7777, 1'b0, 4, 5};
      drive(v); push(v);
      step();
      chk("violation_mov", 128'(MOV), 128'(1));
      d_req = 1'b0; d_addr = 32'hFFF; d_rw = 1'b0; d_size = 2'b01; d_wdata = 32'hFFFF_FFFF;
      drain(40);

      // Asynchronous reset in the middle of a fetch that never sees MOC.
      v = '{SF, 32'h70, 1'b1, 2'b10, 32'h0, NEVER, 32'h0, 32'h0, 1'b0, 0, 0};
      drive(v); push(v);
      repeat (4) step();
      chk("pre_rst_mov", 128'(MOV), 128'(1));
      d_addr = 32'hA00; d_rw = 1'b1; d_size = 2'b10; d_wdata = 32'h0000_0A00; d_req = 1'b1;
      clr = 1'b0;
      #1;
      chk("midrst_mov_busy", 128'({MOV, busy}), 128'(0));
      sb.delete();
      mov_cnt = 0;
      step();
      chk("midrst_no_ack", 128'({if_ack, d_ack, rdata, err}), 128'(0));
      clr = 1'b1;
      v = '{SF, 32'h70, 1'b1, 2'b10, 32'h0, 0, 32'h7070_7070, 32'h7070_7070, 1'b0, 1, 2};
      push(v);
      v = '{SD, 32'hA00, 1'b1, 2'b10, 32'h0000_0A00, 0, 32'hA0A0_A0A0, 32'hA0A0_A0A0, 1'b0, 1, 0};
      push(v);
      drain(40);
      repeat (2) step();
      chk("rdata_held", 128'({rdata, err, busy}), 128'({32'hA0A0_A0A0, 1'b0, 1'b0}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running required done");
      $fatal(1);
   end

endmodule
